rectifier_deadtime: RTL and testbench

RECTIFIER_DEADTIME -- requirements
Module: rectifier_deadtime

---
 rtl/rectifier_deadtime_if.sv | 43 ++++
 rtl/rectifier_deadtime.sv | 162 ++++++++++++++++
 tb/tb_rectifier_deadtime.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rectifier_deadtime_if.sv
`default_nettype none
// ============================================================================
// Module      : rectifier_deadtime_if
// Description : Request, shutdown and gate-drive signal bundle for the
//               three-leg rectifier dead-time generator.
// Revision    : 1.0  initial release
// ============================================================================
interface rectifier_deadtime_if;
    // Raw switching requests, one p/n pair per leg
    logic       Sap;
    logic       San;
    logic       Sbp;
    logic       Sbn;
    logic       Scp;
    logic       Scn;
    // Shutdown (low = all gates off) and fault clear strobe
    logic       SD;
    logic       fault_clr;
    // Gate drives with dead time inserted
    logic       Gap;
    logic       Gan;
    logic       Gbp;
    logic       Gbn;
    logic       Gcp;
    logic       Gcn;
    // Status
    logic       fault;
    logic [2:0] fault_leg;
    logic [2:0] dt_active;

    // Request source side (controller / testbench)
    modport master (
        output Sap, San, Sbp, Sbn, Scp, Scn, SD, fault_clr,
        input  Gap, Gan, Gbp, Gbn, Gcp, Gcn, fault, fault_leg, dt_active
    );

    // Dead-time generator side
    modport slave (
        input  Sap, San, Sbp, Sbn, Scp, Scn, SD, fault_clr,
        output Gap, Gan, Gbp, Gbn, Gcp, Gcn, fault, fault_leg, dt_active
    );
endinterface
`default_nettype wire

// File: rtl/rectifier_deadtime.sv
`default_nettype none
// ============================================================================
// Module      : rectifier_deadtime
// Description : Three independent leg FSMs that turn raw p/n switching
//               requests into registered gate drives with a fixed dead time
//               on every ON->OFF exit, plus sticky shoot-through fault flags.
// Revision    : 1.0  initial release
// ============================================================================
module rectifier_deadtime #(
    parameter int              DT_W      = 10,
    parameter logic [DT_W-1:0] DT_CYCLES = DT_W'(100)
) (
    input  wire logic          sysclk,
    input  wire logic          global_rst,
    rectifier_deadtime_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P_ON = 2'd1,
        ST_N_ON = 2'd2,
        ST_DEAD = 2'd3
    } leg_state_e;

    logic [2:0] req_p;
    logic [2:0] req_n;
    logic [2:0] illegal;
    logic       blocked;

    logic [2:0] fault_leg_q;
    logic [2:0] fault_leg_d;
    logic       fault_q;
    logic       fault_d;

    logic [2:0] gate_p;
    logic [2:0] gate_n;
    logic [2:0] dead;

    assign req_p = {bus.Scp, bus.Sbp, bus.Sap};
    assign req_n = {bus.Scn, bus.Sbn, bus.San};

    // Shoot-through detection and blocking condition shared by all legs
    always_comb begin
        illegal = req_p & req_n;
        blocked = ~bus.SD | fault_q;
        // A new illegal request takes priority over a simultaneous clear
        fault_leg_d = (fault_leg_q & ~{3{bus.fault_clr}}) | illegal;
        // Registered OR of the next per-leg bits keeps fault == |fault_leg
        fault_d = |fault_leg_d;
    end

    // Sticky fault flags
    always_ff @(posedge sysclk or negedge global_rst) begin
        if (!global_rst) begin
            fault_leg_q <= 3'b000;
            fault_q     <= 1'b0;
        end else begin
            fault_leg_q <= fault_leg_d;
            fault_q     <= fault_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_leg
        leg_state_e      state_q;
        leg_state_e      state_d;
        logic [DT_W-1:0] cnt_q;
        logic [DT_W-1:0] cnt_d;
        logic            gp_q;
        logic            gp_d;
        logic            gn_q;
        logic            gn_d;
        logic            dt_q;
        logic            dt_d;
        logic            want_p;
        logic            want_n;

        // Next state, counter and registered outputs for this leg
        always_comb begin
            // Illegal (p=n=1) and blocked both decode as OFF
            want_p  = req_p[i] & ~req_n[i] & ~blocked;
            want_n  = req_n[i] & ~req_p[i] & ~blocked;
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_IDLE: begin
                    if (want_p) begin
                        state_d = ST_P_ON;
                    end else if (want_n) begin
                        state_d = ST_N_ON;
                    end
                end
                ST_P_ON: begin
                    // Any change, even a glitch back to P, costs a full dead time
                    if (!want_p) begin
                        state_d = ST_DEAD;
                        cnt_d   = DT_CYCLES;
                    end
                end
                ST_N_ON: begin
                    if (!want_n) begin
                        state_d = ST_DEAD;
                        cnt_d   = DT_CYCLES;
                    end
                end
                ST_DEAD: begin
                    if (cnt_q <= DT_W'(1)) begin
                        cnt_d = '0;
                        if (want_p) begin
                            state_d = ST_P_ON;
                        end else if (want_n) begin
                            state_d = ST_N_ON;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            gp_d = (state_d == ST_P_ON);
            gn_d = (state_d == ST_N_ON);
            dt_d = (state_d == ST_DEAD);
        end

        // Leg state and output registers
        always_ff @(posedge sysclk or negedge global_rst) begin
            if (!global_rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                gp_q    <= 1'b0;
                gn_q    <= 1'b0;
                dt_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                gp_q    <= gp_d;
                gn_q    <= gn_d;
                dt_q    <= dt_d;
            end
        end

        assign gate_p[i] = gp_q;
        assign gate_n[i] = gn_q;
        assign dead[i]   = dt_q;
    end

    assign bus.Gap       = gate_p[0];
    assign bus.Gan       = gate_n[0];
    assign bus.Gbp       = gate_p[1];
    assign bus.Gbn       = gate_n[1];
    assign bus.Gcp       = gate_p[2];
    assign bus.Gcn       = gate_n[2];
    assign bus.fault     = fault_q;
    assign bus.fault_leg = fault_leg_q;
    assign bus.dt_active = dead;

endmodule
`default_nettype wire

// File: tb/tb_rectifier_deadtime.sv
`default_nettype none
// ============================================================================
// Module      : tb_rectifier_deadtime
// Description : Directed and randomized self-checking bench for
//               rectifier_deadtime with a 4-cycle dead time.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rectifier_deadtime;

    logic sysclk;
    logic global_rst;

    rectifier_deadtime_if bus ();

    rectifier_deadtime #(
        .DT_W      (10),
        .DT_CYCLES (10'd4)
    ) u_dut (
        .sysclk     (sysclk),
        .global_rst (global_rst),
        .bus        (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Random-phase bookkeeping
    int         lowc [3];
    bit         seen [3];
    logic [2:0] pgp;
    logic [2:0] pgn;
    logic [2:0] cgp;
    logic [2:0] cgn;
    int         ov_cnt   = 0;
    int         gap_cnt  = 0;
    int         flt_cnt  = 0;
    int         rise_cnt = 0;
    int         sel;

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // {Gcn,Gcp,Gbn,Gbp,Gan,Gap}
    function automatic logic [5:0] gates();
        return {bus.Gcn, bus.Gcp, bus.Gbn, bus.Gbp, bus.Gan, bus.Gap};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic set_leg(input int leg, input logic p, input logic n);
        case (leg)
            0:       begin bus.Sap = p; bus.San = n; end
            1:       begin bus.Sbp = p; bus.Sbn = n; end
            default: begin bus.Scp = p; bus.Scn = n; end
        endcase
    endtask

    initial begin
        global_rst    = 1'b0;
        bus.Sap       = 1'b0;
        bus.San       = 1'b0;
        bus.Sbp       = 1'b0;
        bus.Sbn       = 1'b0;
        bus.Scp       = 1'b0;
        bus.Scn       = 1'b0;
        bus.SD        = 1'b1;
        bus.fault_clr = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_gates", 32'(gates()), 32'h0);
        chk("rst_fault", 32'(bus.fault), 32'h0);
        chk("rst_fault_leg", 32'(bus.fault_leg), 32'h0);
        chk("rst_dt", 32'(bus.dt_active), 32'h0);

        // Release with all requests off: no gate pulse
        global_rst = 1'b1;
        step();
        step();
        chk("release_quiet", 32'(gates()), 32'h0);

        // Leg a P request: one-edge latency
        bus.Sap = 1'b1;
        step();
        chk("a_p_on", 32'(gates()), 32'h01);
        step();
        chk("a_p_hold", 32'(gates()), 32'h01);

        // P -> N request: 4 dead cycles, then Gan on the 5th edge
        bus.Sap = 1'b0;
        bus.San = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("a_dead_gates_%0d", k), 32'(gates()), 32'h0);
            chk($sformatf("a_dead_dt_%0d", k), 32'(bus.dt_active), 32'h1);
        end
        step();
        chk("a_n_on", 32'(gates()), 32'h02);
        chk("a_n_on_dt", 32'(bus.dt_active), 32'h0);

        // Release leg a: dead time then idle
        bus.San = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("a_idle", 32'(gates()), 32'h0);
        chk("a_idle_dt", 32'(bus.dt_active), 32'h0);

        // Illegal request on leg b
        bus.Sbp = 1'b1;
        bus.Sbn = 1'b1;
        step();
        chk("b_ill_gates", 32'(gates()), 32'h0);
        chk("b_ill_fault", 32'(bus.fault), 32'h1);
        chk("b_ill_leg", 32'(bus.fault_leg), 32'h2);
        bus.Sbp = 1'b0;
        bus.Sbn = 1'b0;
        bus.Sap = 1'b1;
        step();
        chk("fault_sticky", 32'(bus.fault_leg), 32'h2);
        chk("fault_blocks", 32'(gates()), 32'h0);
        bus.fault_clr = 1'b1;
        step();
        chk("clr_fault", 32'(bus.fault), 32'h0);
        chk("clr_leg", 32'(bus.fault_leg), 32'h0);
        bus.fault_clr = 1'b0;
        step();
        chk("after_clr_on", 32'(gates()), 32'h01);

        // Clear and new illegal request together: set wins
        bus.Sap = 1'b0;
        bus.Scp = 1'b1;
        bus.Scn = 1'b1;
        bus.fault_clr = 1'b1;
        step();
        chk("clr_vs_set_leg", 32'(bus.fault_leg), 32'h4);
        chk("clr_vs_set_flt", 32'(bus.fault), 32'h1);
        bus.Scp = 1'b0;
        bus.Scn = 1'b0;
        step();
        chk("clr_again", 32'(bus.fault_leg), 32'h0);
        bus.fault_clr = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("all_idle", 32'(bus.dt_active), 32'h0);

        // Leg c: SD low for one cycle forces a full dead time
        bus.Scp = 1'b1;
        step();
        chk("c_p_on", 32'(gates()), 32'h10);
        bus.SD = 1'b0;
        step();
        chk("sd_gate_off", 32'(gates()), 32'h0);
        chk("sd_dead", 32'(bus.dt_active), 32'h4);
        bus.SD = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            step();
            chk($sformatf("sd_dead_%0d", k), 32'(gates()), 32'h0);
        end
        step();
        chk("sd_resume", 32'(gates()), 32'h10);

        // Reset while leg a is in DEAD with counter at 2
        bus.Sap = 1'b1;
        step();
        chk("a_on_pre_rst", 32'(gates()), 32'h11);
        bus.Sap = 1'b0;
        step();
        step();
        step();
        chk("a_dead_pre_rst", 32'(bus.dt_active), 32'h1);
        global_rst = 1'b0;
        #1;
        chk("async_rst_gates", 32'(gates()), 32'h0);
        chk("async_rst_dt", 32'(bus.dt_active), 32'h0);
        bus.Sap = 1'b1;
        step();
        global_rst = 1'b1;
        step();
        chk("post_rst_on", 32'(gates()), 32'h11);
        chk("post_rst_nodt", 32'(bus.dt_active), 32'h0);

        // Random stimulus with overlap and gap checker
        pgp = {bus.Gcp, bus.Gbp, bus.Gap};
        pgn = {bus.Gcn, bus.Gbn, bus.Gan};
        for (int l = 0; l < 3; l++) begin
            lowc[l] = 0;
            seen[l] = pgp[l] | pgn[l];
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int l = 0; l < 3; l++) begin
                sel = int'($urandom_range(0, 15));
                if (sel == 0)      set_leg(l, 1'b1, 1'b1);
                else if (sel < 6)  set_leg(l, 1'b1, 1'b0);
                else if (sel < 11) set_leg(l, 1'b0, 1'b1);
                else               set_leg(l, 1'b0, 1'b0);
            end
            bus.SD        = ($urandom_range(0, 19) != 0);
            bus.fault_clr = ($urandom_range(0, 3) == 0);
            step();
            cgp = {bus.Gcp, bus.Gbp, bus.Gap};
            cgn = {bus.Gcn, bus.Gbn, bus.Gan};
            if (bus.fault !== (|bus.fault_leg)) flt_cnt++;
            for (int l = 0; l < 3; l++) begin
                if (cgp[l] & cgn[l]) ov_cnt++;
                if ((cgp[l] | cgn[l]) && !(pgp[l] | pgn[l])) begin
                    rise_cnt++;
                    if (seen[l] && lowc[l] < 4) gap_cnt++;
                end
                if (cgp[l] | cgn[l]) begin
                    seen[l] = 1'b1;
                    lowc[l] = 0;
                end else begin
                    lowc[l]++;
                end
            end
            pgp = cgp;
            pgn = cgn;
        end
        chk("rand_overlap", 32'(ov_cnt), 32'h0);
        chk("rand_short_gap", 32'(gap_cnt), 32'h0);
        chk("rand_fault_or", 32'(flt_cnt), 32'h0);
        chk("rand_activity", 32'(rise_cnt > 20), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
